// File: rtl/ray_grid_stepper.sv
// DDA ray/grid-line stepper: walks one family of grid lines (horizontal or vertical) until a wall, the grid edge or the step cap.
// Latency: done in cycle 6+RAM_LAT for a first-cell hit, +4+RAM_LAT per extra miss, cycle 4 for an immediate exit.
// Backpressure: none; start is only sampled in IDLE and ignored while busy (including the DONE cycle).
module ray_grid_stepper #(
    parameter int COORD_W   = 13,
    parameter int CELL_LOG2 = 6,
    parameter int GRID_LOG2 = 6,
    parameter int FRAC_W    = 8,
    parameter int MAX_STEPS = 64,
    parameter int RAM_LAT   = 1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       dir_neg,
    input  logic [COORD_W-1:0]         player_x,
    input  logic [COORD_W-1:0]         player_y,
    input  logic [COORD_W+FRAC_W-1:0]  slope,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic                       out_of_bounds,
    output logic                       step_limit,
    output logic [COORD_W-1:0]         hit_x,
    output logic [COORD_W-1:0]         hit_y,
    output logic [7:0]                 steps,
    output logic                       grid_rd_en,
    output logic [2*GRID_LOG2-1:0]     grid_addr,
    input  logic                       grid_data
);
    // Internal width covers (s<<FRAC_W) plus a full line-to-line slope term with headroom.
    localparam int W    = COORD_W + FRAC_W + CELL_LOG2 + 2;
    localparam int SW   = COORD_W + FRAC_W;
    localparam int CELL = 1 << CELL_LOG2;
    localparam int WC_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic signed [W-1:0] CELL_W = W'(CELL);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_FIRST, S_CHECK, S_READ, S_WAIT, S_EVAL, S_ADVANCE, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                  mode_r, dir_neg_r;
    logic [COORD_W-1:0]    px_r, py_r;
    logic [SW-1:0]         slope_r;
    logic signed [W-1:0]   line_p, step_p, s_acc, step_s;
    logic [WC_W-1:0]       wait_cnt;

    logic signed [W-1:0]   p_w, s_w, slope_w, p_base, line_cell, cell_p, cell_s;
    logic                  cell_ok, at_limit;

    // Primary/secondary coordinates and derived cell indices from the captured ray.
    always_comb begin
        p_w       = mode_r ? {{(W-COORD_W){px_r[COORD_W-1]}}, px_r}
                           : {{(W-COORD_W){py_r[COORD_W-1]}}, py_r};
        s_w       = mode_r ? {{(W-COORD_W){py_r[COORD_W-1]}}, py_r}
                           : {{(W-COORD_W){px_r[COORD_W-1]}}, px_r};
        slope_w   = {{(W-SW){slope_r[SW-1]}}, slope_r};
        p_base    = (p_w >>> CELL_LOG2) <<< CELL_LOG2;
        line_cell = line_p >>> CELL_LOG2;
        // A line crossed while moving toward smaller p bounds the cell below it.
        cell_p    = line_cell - $signed({{(W-1){1'b0}}, dir_neg_r});
        cell_s    = s_acc >>> (FRAC_W + CELL_LOG2);
        // Upper bits all zero means the index is non-negative and below the grid size.
        cell_ok   = (cell_p[W-1:GRID_LOG2] == '0) && (cell_s[W-1:GRID_LOG2] == '0);
        at_limit  = (steps == 8'(MAX_STEPS));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_INIT;
            S_INIT:    state_nxt = S_FIRST;
            S_FIRST:   state_nxt = S_CHECK;
            S_CHECK:   state_nxt = (!cell_ok || at_limit) ? S_DONE : S_READ;
            S_READ:    state_nxt = S_WAIT;
            S_WAIT:    if (wait_cnt == WC_W'(RAM_LAT - 1)) state_nxt = S_EVAL;
            S_EVAL:    state_nxt = grid_data ? S_DONE : S_ADVANCE;
            S_ADVANCE: state_nxt = S_CHECK;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        grid_rd_en = (state == S_READ);
    end

    // Datapath: capture, line/accumulator stepping, probe address and result registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mode_r        <= 1'b0;
            dir_neg_r     <= 1'b0;
            px_r          <= '0;
            py_r          <= '0;
            slope_r       <= '0;
            line_p        <= '0;
            step_p        <= '0;
            s_acc         <= '0;
            step_s        <= '0;
            wait_cnt      <= '0;
            hit           <= 1'b0;
            out_of_bounds <= 1'b0;
            step_limit    <= 1'b0;
            hit_x         <= '0;
            hit_y         <= '0;
            steps         <= '0;
            grid_addr     <= '0;
        end else begin
            // Report the grid-line crossing point whenever the walk terminates.
            if (state_nxt == S_DONE && state != S_DONE) begin
                hit_x <= mode_r ? line_p[COORD_W-1:0] : s_acc[FRAC_W +: COORD_W];
                hit_y <= mode_r ? s_acc[FRAC_W +: COORD_W] : line_p[COORD_W-1:0];
            end
            case (state)
                S_IDLE: if (start) begin
                    mode_r    <= mode;
                    dir_neg_r <= dir_neg;
                    px_r      <= player_x;
                    py_r      <= player_y;
                    slope_r   <= slope;
                end
                S_INIT: begin
                    line_p        <= dir_neg_r ? p_base : p_base + CELL_W;
                    step_p        <= dir_neg_r ? -CELL_W : CELL_W;
                    steps         <= '0;
                    hit           <= 1'b0;
                    out_of_bounds <= 1'b0;
                    step_limit    <= 1'b0;
                end
                S_FIRST: begin
                    s_acc  <= (s_w <<< FRAC_W) + (line_p - p_w) * slope_w;
                    step_s <= step_p * slope_w;
                end
                S_CHECK: begin
                    if (!cell_ok)      out_of_bounds <= 1'b1;
                    else if (at_limit) step_limit    <= 1'b1;
                    else grid_addr <= mode_r ? {cell_s[GRID_LOG2-1:0], cell_p[GRID_LOG2-1:0]}
                                             : {cell_p[GRID_LOG2-1:0], cell_s[GRID_LOG2-1:0]};
                end
                S_READ:  wait_cnt <= '0;
                S_WAIT:  wait_cnt <= wait_cnt + 1'b1;
                S_EVAL: begin
                    steps <= steps + 8'd1;
                    if (grid_data) hit <= 1'b1;
                end
                S_ADVANCE: begin
                    // Full-precision accumulation keeps the secondary coordinate drift-free.
                    line_p <= line_p + step_p;
                    s_acc  <= s_acc + step_s;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_grid_stepper.sv
// Bench for ray_grid_stepper: three instances (defaults, MAX_STEPS=16, RAM_LAT=3) each with its own RAM pipeline.
// Directed scenarios plus randomized rays checked against a closed-form walk model.
// Outputs sampled on the falling edge; cycle k means the cycle after the k-th rising edge following start.
module tb_ray_grid_stepper;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  start_v = 3'b0;
    logic        mode = 1'b0, dir_neg = 1'b0;
    logic [12:0] player_x = '0, player_y = '0;
    logic [20:0] slope = '0;

    logic [2:0]  busy_v, done_v, hit_v, oob_v, lim_v, rd_v, gdata_v;
    logic [12:0] hx_v [3];
    logic [12:0] hy_v [3];
    logic [7:0]  steps_v [3];
    logic [11:0] addr_v [3];

    logic        wall [0:4095];
    logic [2:0]  dpipe [3];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, c0 = 0, last_lat = 0;
    logic [11:0] rd_q[$];
    int          rdc_q[$];
    logic [11:0] exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM models: data appears RAM_LAT edges after the read strobe and holds until the next read.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_v[i]) dpipe[i][0] <= wall[addr_v[i]];
            dpipe[i][2:1] <= dpipe[i][1:0];
        end
    end
    assign gdata_v[0] = dpipe[0][0];
    assign gdata_v[1] = dpipe[1][0];
    assign gdata_v[2] = dpipe[2][2];

    ray_grid_stepper u0 (
        .clock(clock), .resetn(resetn), .start(start_v[0]), .mode(mode), .dir_neg(dir_neg),
        .player_x(player_x), .player_y(player_y), .slope(slope),
        .busy(busy_v[0]), .done(done_v[0]), .hit(hit_v[0]), .out_of_bounds(oob_v[0]),
        .step_limit(lim_v[0]), .hit_x(hx_v[0]), .hit_y(hy_v[0]), .steps(steps_v[0]),
        .grid_rd_en(rd_v[0]), .grid_addr(addr_v[0]), .grid_data(gdata_v[0]));

    ray_grid_stepper #(.MAX_STEPS(16)) u1 (
        .clock(clock), .resetn(resetn), .start(start_v[1]), .mode(mode), .dir_neg(dir_neg),
        .player_x(player_x), .player_y(player_y), .slope(slope),
        .busy(busy_v[1]), .done(done_v[1]), .hit(hit_v[1]), .out_of_bounds(oob_v[1]),
        .step_limit(lim_v[1]), .hit_x(hx_v[1]), .hit_y(hy_v[1]), .steps(steps_v[1]),
        .grid_rd_en(rd_v[1]), .grid_addr(addr_v[1]), .grid_data(gdata_v[1]));

    ray_grid_stepper #(.RAM_LAT(3)) u2 (
        .clock(clock), .resetn(resetn), .start(start_v[2]), .mode(mode), .dir_neg(dir_neg),
        .player_x(player_x), .player_y(player_y), .slope(slope),
        .busy(busy_v[2]), .done(done_v[2]), .hit(hit_v[2]), .out_of_bounds(oob_v[2]),
        .step_limit(lim_v[2]), .hit_x(hx_v[2]), .hit_y(hy_v[2]), .steps(steps_v[2]),
        .grid_rd_en(rd_v[2]), .grid_addr(addr_v[2]), .grid_data(gdata_v[2]));

    task automatic set_in(input bit md, input bit dn, input int px, input int py, input int sl);
        mode = md; dir_neg = dn;
        player_x = 13'(px); player_y = 13'(py); slope = 21'(sl);
    endtask

    task automatic clear_walls();
        for (int a = 0; a < 4096; a++) wall[a] = 1'b0;
    endtask

    // Pulse start for one cycle; afterwards we sit in cycle 1.
    task automatic kick(input int inst);
        rd_q.delete(); rdc_q.delete();
        @(negedge clock); start_v[inst] = 1'b1;
        @(negedge clock); start_v[inst] = 1'b0;
        c0 = cyc - 1;
    endtask

    // Watch reads and stop on the falling edge where done is high.
    task automatic wait_done(input int inst);
        bit got = 1'b0;
        int i = 0;
        while (!got && i < 3000) begin
            if (rd_v[inst]) begin rd_q.push_back(addr_v[inst]); rdc_q.push_back(cyc - c0); end
            if (done_v[inst]) begin got = 1'b1; last_lat = cyc - c0; end
            else begin @(negedge clock); i++; end
        end
        if (!got) begin
            n_cmp++; n_bad++; last_lat = -1;
            $display("FAIL timeout inst%0d: done not seen, required within 3000 cycles", inst);
        end
    endtask

    task automatic run(input int inst);
        kick(inst);
        wait_done(inst);
    endtask

    // Walk the grid lines in closed form: k-th line is line0 + k*step, secondary from the exact slope product.
    task automatic model(input bit md, input bit dn, input int px, input int py, input int sl, input int maxs,
                         output logic [2:0] fl, output logic [12:0] hx, output logic [12:0] hy, output int st);
        int p, s, line0, stp, line, pc, sc, a;
        longint sf;
        bit fin;
        exp_q.delete();
        p = md ? px : py; s = md ? py : px;
        line0 = (p >>> 6) * 64 + (dn ? 0 : 64);
        stp = dn ? -64 : 64;
        fin = 1'b0; fl = 3'b000; st = 0; hx = '0; hy = '0;
        for (int k = 0; !fin && k <= 300; k++) begin
            line = line0 + k * stp;
            sf = longint'(s) * 256 + longint'(line - p) * longint'(sl);
            sc = int'(sf >>> 14);
            pc = (line >>> 6) - (dn ? 1 : 0);
            hx = md ? 13'(line) : 13'(sf >>> 8);
            hy = md ? 13'(sf >>> 8) : 13'(line);
            if (pc < 0 || pc > 63 || sc < 0 || sc > 63) begin fl = 3'b010; st = k; fin = 1'b1; end
            else if (k == maxs) begin fl = 3'b001; st = k; fin = 1'b1; end
            else begin
                a = md ? sc * 64 + pc : pc * 64 + sc;
                exp_q.push_back(12'(a));
                if (wall[a]) begin fl = 3'b100; st = k + 1; fin = 1'b1; end
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({busy_v[i], done_v[i], hit_v[i], oob_v[i], lim_v[i], rd_v[i]} !== 6'b0 ||
                hx_v[i] !== 13'd0 || hy_v[i] !== 13'd0 || steps_v[i] !== 8'd0 || addr_v[i] !== 12'd0) begin
                n_bad++;
                $display("FAIL reset inst%0d: ctl=%b hx=%0d hy=%0d steps=%0d addr=%0d, required all zero",
                         i, {busy_v[i], done_v[i], hit_v[i], oob_v[i], lim_v[i], rd_v[i]},
                         hx_v[i], hy_v[i], steps_v[i], addr_v[i]);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_first_hit(input int inst, input int lat);
        clear_walls(); wall[129] = 1'b1;
        set_in(1'b0, 1'b1, 100, 200, 0);
        run(inst);
        n_cmp++;
        if (last_lat !== lat || {hit_v[inst], oob_v[inst], lim_v[inst]} !== 3'b100 || busy_v[inst] !== 1'b1) begin
            n_bad++;
            $display("FAIL first_hit inst%0d: lat=%0d flags=%b busy=%b, required lat=%0d flags=100 busy=1",
                     inst, last_lat, {hit_v[inst], oob_v[inst], lim_v[inst]}, busy_v[inst], lat);
        end
        n_cmp++;
        if (hx_v[inst] !== 13'd100 || hy_v[inst] !== 13'd192 || steps_v[inst] !== 8'd1) begin
            n_bad++;
            $display("FAIL first_hit_pos inst%0d: (%0d,%0d) steps=%0d, required (100,192) steps=1",
                     inst, hx_v[inst], hy_v[inst], steps_v[inst]);
        end
        n_cmp++;
        if (rd_q.size() != 1 || rd_q[0] !== 12'd129 || rdc_q[0] != 4) begin
            n_bad++;
            $display("FAIL first_hit_rd inst%0d: %0d reads, first addr=%0d at cycle %0d, required one read of 129 at cycle 4",
                     inst, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 12'd0, (rdc_q.size() > 0) ? rdc_q[0] : -1);
        end
    endtask

    task automatic test_slope_walk();
        clear_walls(); wall[322] = 1'b1;
        set_in(1'b0, 1'b0, 100, 200, 128);
        run(0);
        n_cmp++;
        if (rd_q.size() != 2 || rd_q[0] !== 12'd258 || rd_q[1] !== 12'd322) begin
            n_bad++;
            $display("FAIL slope_reads: %0d reads, required 258 then 322", rd_q.size());
        end
        n_cmp++;
        if (hx_v[0] !== 13'd160 || hy_v[0] !== 13'd320 || steps_v[0] !== 8'd2 || last_lat != 12 || hit_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL slope_result: (%0d,%0d) steps=%0d lat=%0d hit=%b, required (160,320) steps=2 lat=12 hit=1",
                     hx_v[0], hy_v[0], steps_v[0], last_lat, hit_v[0]);
        end
    endtask

    task automatic test_vertical();
        clear_walls(); wall[194] = 1'b1;
        set_in(1'b1, 1'b0, 100, 200, 0);
        run(0);
        n_cmp++;
        if (hx_v[0] !== 13'd128 || hy_v[0] !== 13'd200 || steps_v[0] !== 8'd1 || hit_v[0] !== 1'b1 || last_lat != 7) begin
            n_bad++;
            $display("FAIL vertical: (%0d,%0d) steps=%0d hit=%b lat=%0d, required (128,200) steps=1 hit=1 lat=7",
                     hx_v[0], hy_v[0], steps_v[0], hit_v[0], last_lat);
        end
    endtask

    task automatic test_oob();
        clear_walls();
        set_in(1'b0, 1'b1, 100, 30, 0);
        run(0);
        n_cmp++;
        if ({hit_v[0], oob_v[0], lim_v[0]} !== 3'b010 || steps_v[0] !== 8'd0 || rd_q.size() != 0 || last_lat != 4) begin
            n_bad++;
            $display("FAIL oob_immediate: flags=%b steps=%0d reads=%0d lat=%0d, required flags=010 steps=0 reads=0 lat=4",
                     {hit_v[0], oob_v[0], lim_v[0]}, steps_v[0], rd_q.size(), last_lat);
        end
        set_in(1'b0, 1'b0, 100, 200, 0);
        run(0);
        n_cmp++;
        if ({hit_v[0], oob_v[0], lim_v[0]} !== 3'b010 || steps_v[0] !== 8'd60 || rd_q.size() != 60 ||
            last_lat != 304 || hy_v[0] !== 13'h1000) begin
            n_bad++;
            $display("FAIL oob_walk: flags=%b steps=%0d reads=%0d lat=%0d hy=%h, required flags=010 steps=60 reads=60 lat=304 hy=1000",
                     {hit_v[0], oob_v[0], lim_v[0]}, steps_v[0], rd_q.size(), last_lat, hy_v[0]);
        end
    endtask

    task automatic test_step_limit();
        clear_walls();
        set_in(1'b0, 1'b0, 100, 200, 0);
        run(1);
        n_cmp++;
        if ({hit_v[1], oob_v[1], lim_v[1]} !== 3'b001 || steps_v[1] !== 8'd16 || last_lat != 84 ||
            hx_v[1] !== 13'd100 || hy_v[1] !== 13'd1280) begin
            n_bad++;
            $display("FAIL step_limit: flags=%b steps=%0d lat=%0d (%0d,%0d), required flags=001 steps=16 lat=84 (100,1280)",
                     {hit_v[1], oob_v[1], lim_v[1]}, steps_v[1], last_lat, hx_v[1], hy_v[1]);
        end
    endtask

    task automatic test_reset_abort();
        int dn_cnt = 0;
        clear_walls(); wall[322] = 1'b1;
        set_in(1'b0, 1'b0, 100, 200, 128);
        kick(0);
        repeat (4) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({busy_v[0], done_v[0], hit_v[0], oob_v[0], lim_v[0], rd_v[0]} !== 6'b0 ||
            hx_v[0] !== 13'd0 || hy_v[0] !== 13'd0 || steps_v[0] !== 8'd0 || addr_v[0] !== 12'd0) begin
            n_bad++;
            $display("FAIL abort_reset: ctl=%b hx=%0d hy=%0d steps=%0d addr=%0d, required all zero",
                     {busy_v[0], done_v[0], hit_v[0], oob_v[0], lim_v[0], rd_v[0]}, hx_v[0], hy_v[0], steps_v[0], addr_v[0]);
        end
        resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (done_v[0] || busy_v[0]) dn_cnt++;
        end
        n_cmp++;
        if (dn_cnt != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: done/busy seen in %0d cycles after reset, required 0", dn_cnt);
        end
    endtask

    task automatic test_start_busy();
        int busy_cnt = 0;
        clear_walls(); wall[129] = 1'b1;
        set_in(1'b0, 1'b1, 100, 200, 0);
        kick(0);
        repeat (2) @(negedge clock);
        set_in(1'b1, 1'b0, 500, 900, 64);
        start_v[0] = 1'b1;
        @(negedge clock); start_v[0] = 1'b0;
        wait_done(0);
        n_cmp++;
        if (last_lat != 7 || hx_v[0] !== 13'd100 || hy_v[0] !== 13'd192 || steps_v[0] !== 8'd1 || hit_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL start_busy: lat=%0d (%0d,%0d) steps=%0d hit=%b, required lat=7 (100,192) steps=1 hit=1",
                     last_lat, hx_v[0], hy_v[0], steps_v[0], hit_v[0]);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (busy_v[0]) busy_cnt++;
        end
        n_cmp++;
        if (busy_cnt != 0) begin
            n_bad++;
            $display("FAIL start_busy_idle: busy in %0d cycles after done, required 0", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d[2];
        int nd = 0;
        logic b8 = 1'b1;
        clear_walls(); wall[129] = 1'b1; wall[194] = 1'b1;
        set_in(1'b0, 1'b1, 100, 200, 0);
        d[0] = -1; d[1] = -1;
        @(negedge clock); start_v[0] = 1'b1;
        @(negedge clock); c0 = cyc - 1;
        for (int k = 0; k < 60 && nd < 2; k++) begin
            if (cyc - c0 == 8) b8 = busy_v[0];
            if (done_v[0]) begin
                d[nd] = cyc - c0; nd++;
                if (nd == 1) set_in(1'b1, 1'b0, 100, 200, 0);
            end
            if (nd == 2) start_v[0] = 1'b0;
            else @(negedge clock);
        end
        start_v[0] = 1'b0;
        n_cmp++;
        if (d[0] != 7 || d[1] != 15 || b8 !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_back: done at %0d and %0d, busy@8=%b, required 7 and 15, busy@8=0", d[0], d[1], b8);
        end
        n_cmp++;
        if (hx_v[0] !== 13'd128 || hy_v[0] !== 13'd200) begin
            n_bad++;
            $display("FAIL back_to_back_recapture: (%0d,%0d), required (128,200)", hx_v[0], hy_v[0]);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        int maxs_t[3] = '{64, 16, 64};
        int lat_t[3]  = '{1, 1, 3};
        int inst, px, py, sl, st, elat;
        bit md, dn, addr_ok;
        logic [2:0]  fl;
        logic [12:0] hx, hy;
        for (int it = 0; it < 45; it++) begin
            inst = it % 3;
            for (int a = 0; a < 4096; a++) wall[a] = ($urandom_range(0, 11) == 0);
            md = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1));
            px = int'($urandom_range(0, 4095)); py = int'($urandom_range(0, 4095));
            sl = (it % 2 == 0) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 4095)) - 2048;
            set_in(md, dn, px, py, sl);
            model(md, dn, px, py, sl, maxs_t[inst], fl, hx, hy, st);
            elat = (fl == 3'b100) ? 6 + lat_t[inst] + (st - 1) * (4 + lat_t[inst]) : 4 + st * (4 + lat_t[inst]);
            run(inst);
            n_cmp++;
            if ({hit_v[inst], oob_v[inst], lim_v[inst]} !== fl || steps_v[inst] !== 8'(st)) begin
                n_bad++;
                $display("FAIL rand%0d_result: flags=%b steps=%0d, required flags=%b steps=%0d",
                         it, {hit_v[inst], oob_v[inst], lim_v[inst]}, steps_v[inst], fl, st);
            end
            n_cmp++;
            if (hx_v[inst] !== hx || hy_v[inst] !== hy) begin
                n_bad++;
                $display("FAIL rand%0d_pos: (%0d,%0d), required (%0d,%0d)", it, hx_v[inst], hy_v[inst], hx, hy);
            end
            addr_ok = (rd_q.size() == exp_q.size());
            for (int j = 0; addr_ok && j < rd_q.size(); j++) if (rd_q[j] !== exp_q[j]) addr_ok = 1'b0;
            n_cmp++;
            if (!addr_ok) begin
                n_bad++;
                $display("FAIL rand%0d_reads: %0d reads issued, required %0d matching addresses", it, rd_q.size(), exp_q.size());
            end
            n_cmp++;
            if (last_lat != elat) begin
                n_bad++;
                $display("FAIL rand%0d_latency: done at cycle %0d, required %0d", it, last_lat, elat);
            end
        end
    endtask

    initial begin
        clear_walls();
        for (int i = 0; i < 3; i++) dpipe[i] = 3'b0;
        test_reset();
        test_first_hit(0, 7);
        test_slope_walk();
        test_vertical();
        test_oob();
        test_step_limit();
        test_first_hit(2, 9);
        test_reset_abort();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
